pipe_phy_cmd_responder: RTL
===========================

PIPE_PHY_CMD_RESPONDER -- requirements
Module: pipe_phy_cmd_responder

Interface
REQ-001 Params SHALL be: RESET_CYCLES, default 16, PhyStatus hold after reset; PD_LATENCY, default 4, PowerDown completion delay; RATE_LATENCY, default 8, Rate completion delay; DETECT_LATENCY, default 12, receiver-detect delay; all in range 1..255.
REQ-002 CLK  in  1  single PHY-side clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  SHALL be synchronous, active-low.
REQ-004 PowerDown  in  4  MAC power-state request (P0=0, P0s=1, P1=2, P2=3).
REQ-005 Rate  in  4  MAC rate request.
REQ-006 TxDetectRx_Loopback  in  1  receiver-detect request.
REQ-007 TxElecIdle  in  1  transmitter idle.
REQ-008 rx_present  in  1  far-end termination sensed (model input).
REQ-009 PclkChangeAck  in  1  MAC acknowledges PCLK change.
REQ-010 PhyStatus  out  1  completion/reset status.
REQ-011 RxStatus  out  3  detect result.
REQ-012 PclkChangeOk  out  1  PHY ready for PCLK change.
REQ-013 cur_powerdown  out  4  committed power state; cur_rate  out  4  committed rate.

Function
REQ-014 FSM states SHALL be RST_HOLD, IDLE, PD_WAIT, RATE_WAIT, PCLK_OK, DET_WAIT, DONE.
REQ-015 RST_HOLD: PhyStatus=1 for RESET_CYCLES cycles after reset release, then PhyStatus=0 -> IDLE.
REQ-016 IDLE priority: Rate!=cur_rate -> RATE_WAIT; else PowerDown!=cur_powerdown -> PD_WAIT; else cur_powerdown==P1 && TxDetectRx_Loopback && TxElecIdle -> DET_WAIT.
REQ-017 Request value SHALL be sampled on the IDLE exit cycle; input changes during non-IDLE states ignored; differences re-evaluated on return to IDLE (no request lost, last value wins).
REQ-018 PD_WAIT: after PD_LATENCY cycles commit cur_powerdown -> DONE.
REQ-019 RATE_WAIT: after RATE_LATENCY cycles -> PCLK_OK (macro on) or commit cur_rate -> DONE (macro off).
REQ-020 DET_WAIT: after DETECT_LATENCY cycles set RxStatus=3'b011 if rx_present else 3'b000 -> DONE.
REQ-021 DONE: PhyStatus=1 exactly one cycle -> IDLE; RxStatus returns to 3'b000 next cycle.
REQ-022 Latency N SHALL mean PhyStatus asserts N+1 cycles after IDLE exit; 8-bit down-counter, no wrap.
REQ-023 PhyStatus SHALL never be high outside RST_HOLD and DONE; RxStatus nonzero only in DONE.

Reset
REQ-024 reset=0 SHALL force: state RST_HOLD, PhyStatus=1, RxStatus=0, PclkChangeOk=0, cur_powerdown=P1, cur_rate=0, counter=RESET_CYCLES-1.
REQ-025 Reset asserted mid-operation SHALL abort any transaction without a DONE pulse.

Configuration
REQ-026 PIPE_PCLK_HANDSHAKE_EN defined: PCLK_OK asserts PclkChangeOk, waits indefinitely for PclkChangeAck=1, then clears PclkChangeOk, commits cur_rate -> DONE.
REQ-027 Undefined: PCLK_OK state, PclkChangeAck logic absent; PclkChangeOk tied 0.

Structure
REQ-028 Package pipe_pkg SHALL hold PowerDown encodings, RxStatus codes (RX_DET=3'b011, RX_OK=3'b000) and FSM state enum.
REQ-029 One sub-module pipe_lat_counter (load, decrement, zero flag) SHALL implement all delays.

Verification
REQ-030 Reset release, defaults -> PhyStatus high 16 cycles, low on cycle 17, cur_powerdown=2.
REQ-031 PowerDown 2->0 in IDLE -> single PhyStatus pulse 5 cycles later, cur_powerdown=0.
REQ-032 P1, TxElecIdle=1, TxDetectRx_Loopback=1, rx_present=1 -> at cycle 13 PhyStatus=1 with RxStatus=3'b011; rx_present=0 gives 3'b000.
REQ-033 Rate 0->1 and PowerDown 2->0 same cycle -> rate pulse at +9, powerdown pulse 5 cycles after re-entering IDLE.
REQ-034 Macro on, Rate 0->2 -> PclkChangeOk=1 at +9, held 20 cycles until PclkChangeAck, then PhyStatus pulse next cycle, cur_rate=2.
REQ-035 reset=0 during PD_WAIT -> no DONE pulse, RST_HOLD sequence restarts, cur_powerdown=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared encodings for the PIPE PHY command responder:
//   - PowerDown encodings (P0, P0s, P1, P2)
//   - RxStatus codes for receiver detection
//   - responder FSM state enum
//   - helper to turn a latency into a down-counter load value
// Optional feature macro: PIPE_PCLK_HANDSHAKE_EN adds the PCLK_OK state.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [3:0] PD_P0  = 4'd0;
  localparam logic [3:0] PD_P0S = 4'd1;
  localparam logic [3:0] PD_P1  = 4'd2;
  localparam logic [3:0] PD_P2  = 4'd3;

  localparam logic [2:0] RX_DET = 3'b011;  // far-end receiver present
  localparam logic [2:0] RX_OK  = 3'b000;  // nothing detected / no status

  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    IDLE      = 3'd1,
    PD_WAIT   = 3'd2,
    RATE_WAIT = 3'd3,
    DET_WAIT  = 3'd4,
    DONE      = 3'd5
`ifdef PIPE_PCLK_HANDSHAKE_EN
    , PCLK_OK = 3'd6
`endif
  } state_t;

  // A wait state of N cycles starts with the counter at N-1 and leaves on zero.
  function automatic logic [7:0] lat_load(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/pipe_lat_counter.sv
// -----------------------------------------------------------------------------
// pipe_lat_counter
// 8-bit loadable down-counter used for every responder delay. Saturates at
// zero (never wraps) and reports a zero flag.
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset, loads RST_VAL
//   i_load     load i_load_val (has priority over decrement)
//   i_load_val value to load
//   i_dec      decrement when nonzero
//   o_zero     counter is zero
// -----------------------------------------------------------------------------
module pipe_lat_counter #(
  parameter logic [7:0] RST_VAL = 8'd15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering; reset is sampled on the
  // clock edge (synchronous), so it sits inside the clocked branch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/pipe_phy_cmd_responder.sv
// -----------------------------------------------------------------------------
// pipe_phy_cmd_responder
// Behavioural PIPE PHY responder: holds PhyStatus after reset, then answers MAC
// PowerDown / Rate / receiver-detect requests with a one-cycle PhyStatus pulse
// after a programmable latency. A latency of N puts the pulse N+1 cycles after
// the cycle in which IDLE was left.
// Optional feature macro: PIPE_PCLK_HANDSHAKE_EN -- rate changes wait in
// PCLK_OK with PclkChangeOk high until PclkChangeAck before committing.
// Ports:
//   CLK                  PHY clock, rising edge
//   reset                synchronous active-low reset
//   PowerDown[3:0]       requested power state
//   Rate[3:0]            requested rate
//   TxDetectRx_Loopback  receiver-detect request (with TxElecIdle, in P1)
//   TxElecIdle           transmitter electrical idle
//   rx_present           modelled far-end termination
//   PclkChangeAck        MAC acknowledge of PCLK change
//   PhyStatus            reset hold / completion pulse
//   RxStatus[2:0]        detect result, valid only during the completion pulse
//   PclkChangeOk         PHY ready for PCLK change
//   cur_powerdown[3:0]   committed power state
//   cur_rate[3:0]        committed rate
// -----------------------------------------------------------------------------
module pipe_phy_cmd_responder
  import pipe_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned PD_LATENCY     = 4,
  parameter int unsigned RATE_LATENCY   = 8,
  parameter int unsigned DETECT_LATENCY = 12
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] PowerDown,
  input  logic [3:0] Rate,
  input  logic       TxDetectRx_Loopback,
  input  logic       TxElecIdle,
  input  logic       rx_present,
  input  logic       PclkChangeAck,
  output logic       PhyStatus,
  output logic [2:0] RxStatus,
  output logic       PclkChangeOk,
  output logic [3:0] cur_powerdown,
  output logic [3:0] cur_rate
);

  localparam logic [7:0] L_RST  = lat_load(RESET_CYCLES);
  localparam logic [7:0] L_PD   = lat_load(PD_LATENCY);
  localparam logic [7:0] L_RATE = lat_load(RATE_LATENCY);
  localparam logic [7:0] L_DET  = lat_load(DETECT_LATENCY);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_req_pd;
  logic [3:0] r_req_rate;
  logic [3:0] r_cur_pd;
  logic [3:0] r_cur_rate;
  logic [2:0] r_rx_status;

  logic       w_load;
  logic [7:0] w_load_val;
  logic       w_dec;
  logic       w_zero;
  logic       w_commit_pd;
  logic       w_commit_rate;
  logic       w_det_done;

  pipe_lat_counter #(.RST_VAL(L_RST)) u_lat (
    .i_clk      (CLK),
    .i_rst_n    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_load_val    = 8'd0;
    w_dec         = 1'b0;
    w_commit_pd   = 1'b0;
    w_commit_rate = 1'b0;
    w_det_done    = 1'b0;
    case (r_state)
      RST_HOLD: begin
        w_dec = 1'b1;
        if (w_zero) w_next = IDLE;
      end
      IDLE: begin
        // Rate changes take priority; a pending PowerDown difference is seen
        // again when the rate transaction returns here.
        if (Rate != r_cur_rate) begin
          w_next     = RATE_WAIT;
          w_load     = 1'b1;
          w_load_val = L_RATE;
        end else if (PowerDown != r_cur_pd) begin
          w_next     = PD_WAIT;
          w_load     = 1'b1;
          w_load_val = L_PD;
        end else if ((r_cur_pd == PD_P1) && TxDetectRx_Loopback && TxElecIdle) begin
          w_next     = DET_WAIT;
          w_load     = 1'b1;
          w_load_val = L_DET;
        end
      end
      PD_WAIT: begin
        w_dec = 1'b1;
        if (w_zero) begin
          w_next      = DONE;
          w_commit_pd = 1'b1;
        end
      end
      RATE_WAIT: begin
        w_dec = 1'b1;
        if (w_zero) begin
`ifdef PIPE_PCLK_HANDSHAKE_EN
          w_next = PCLK_OK;
`else
          w_next        = DONE;
          w_commit_rate = 1'b1;
`endif
        end
      end
`ifdef PIPE_PCLK_HANDSHAKE_EN
      PCLK_OK: begin
        if (PclkChangeAck) begin
          w_next        = DONE;
          w_commit_rate = 1'b1;
        end
      end
`endif
      DET_WAIT: begin
        w_dec = 1'b1;
        if (w_zero) begin
          w_next     = DONE;
          w_det_done = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = RST_HOLD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state     <= RST_HOLD;
      r_req_pd    <= PD_P1;
      r_req_rate  <= 4'd0;
      r_cur_pd    <= PD_P1;
      r_cur_rate  <= 4'd0;
      r_rx_status <= RX_OK;
    end else begin
      r_state <= w_next;
      // Requests are frozen on the IDLE exit edge; later input changes wait.
      if (w_load) begin
        r_req_pd   <= PowerDown;
        r_req_rate <= Rate;
      end
      if (w_commit_pd)   r_cur_pd   <= r_req_pd;
      if (w_commit_rate) r_cur_rate <= r_req_rate;
      // Detect result lives only for the DONE cycle.
      if (w_det_done) begin
        r_rx_status <= rx_present ? RX_DET : RX_OK;
      end else if (r_state == DONE) begin
        r_rx_status <= RX_OK;
      end
    end
  end

  assign PhyStatus     = (r_state == RST_HOLD) || (r_state == DONE);
  assign RxStatus      = r_rx_status;
  assign cur_powerdown = r_cur_pd;
  assign cur_rate      = r_cur_rate;

`ifdef PIPE_PCLK_HANDSHAKE_EN
  assign PclkChangeOk = (r_state == PCLK_OK);
`else
  assign PclkChangeOk = 1'b0;
  logic w_unused;
  assign w_unused = PclkChangeAck;
`endif

endmodule
